// File: rtl/lab1_bit_serializer.sv
// Parallel-to-serial shifter with a valid/ready load port and a hold input.
// Back-to-back words run with no gap; done pulses once per retired word.
module lab1_bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_done;

  logic             w_idle;
  logic             w_shift;
  logic             w_last;
  logic             w_retire;
  logic             w_head;
  logic [WIDTH-1:0] w_next;

  assign w_idle   = (r_state == S_IDLE);
  assign w_shift  = (r_state == S_SHIFT);
  assign w_last   = (r_cnt == LAST);
  assign w_retire = w_shift && w_last && !hold;

  // The presented bit always sits at the outgoing end of r_shift.
  assign w_head = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
  assign w_next = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);

  assign load_ready = w_idle || w_retire;
  assign ser_out    = w_shift ? w_head : IDLE_LEVEL;
  assign ser_valid  = w_shift && !hold;
  assign busy       = w_shift;
  assign done       = r_done;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_retire;
      case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_state <= S_SHIFT;
            r_shift <= data_in;
            r_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          if (!hold) begin
            if (w_last) begin
              // Chain the next word straight in, or fall back to idle.
              if (load_valid) begin
                r_shift <= data_in;
                r_cnt   <= '0;
              end else begin
                r_state <= S_IDLE;
                r_shift <= '0;
                r_cnt   <= '0;
              end
            end else begin
              r_shift <= w_next;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_shift <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_bit_serializer.sv
// Scoreboard bench for lab1_bit_serializer: an MSB-first unit with idle
// level 0, plus an LSB-first unit with idle level 1 on the same stimulus.
module tb_lab1_bit_serializer;

  logic       clk;
  logic       rstb;
  logic [7:0] data_in;
  logic       load_valid;
  logic       hold;

  logic a_ready, a_ser, a_valid, a_busy, a_done;
  logic b_ready, b_ser, b_valid, b_busy, b_done;

  int n_checks;
  int n_pass;
  logic q[$];
  logic e;

  lab1_bit_serializer #(
    .WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .rstb(rstb), .data_in(data_in),
    .load_valid(load_valid), .load_ready(a_ready),
    .hold(hold), .ser_out(a_ser), .ser_valid(a_valid),
    .busy(a_busy), .done(a_done)
  );

  lab1_bit_serializer #(
    .WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)
  ) dut_b (
    .clk(clk), .rstb(rstb), .data_in(data_in),
    .load_valid(load_valid), .load_ready(b_ready),
    .hold(hold), .ser_out(b_ser), .ser_valid(b_valid),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_msb(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q.push_back(w[i]);
  endtask

  task automatic push_lsb(input logic [7:0] w);
    for (int i = 0; i < 8; i++) q.push_back(w[i]);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    load_valid = 1'b0;
    hold = 1'b0;
    data_in = '0;
    #3;
    n_checks++;
    if (a_ser !== 1'b0) $display("FAIL rst_ser got=%b exp=0", a_ser);
    else n_pass++;
    n_checks++;
    if (a_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", a_valid);
    else n_pass++;
    n_checks++;
    if (a_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", a_busy);
    else n_pass++;
    n_checks++;
    if (a_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", a_done);
    else n_pass++;
    n_checks++;
    if (a_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", a_ready);
    else n_pass++;
    n_checks++;
    if (b_ser !== 1'b1) $display("FAIL rst_idle_lvl got=%b exp=1", b_ser);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    data_in = 8'hB0;
    load_valid = 1'b1;
    q.delete();
    push_msb(8'hB0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      load_valid = 1'b0;
      data_in = 8'h00;
      #1;
      n_checks++;
      if (a_valid !== (c <= 8))
        $display("FAIL single_valid c=%0d got=%b exp=%b", c, a_valid, c <= 8);
      else n_pass++;
      if (a_valid && q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (a_ser !== e) $display("FAIL single_bit c=%0d got=%b exp=%b", c, a_ser, e);
        else n_pass++;
      end else begin
        n_checks++;
        if (a_ser !== 1'b0) $display("FAIL single_idle c=%0d got=%b exp=0", c, a_ser);
        else n_pass++;
      end
      n_checks++;
      if (a_done !== (c == 9))
        $display("FAIL single_done c=%0d got=%b exp=%b", c, a_done, c == 9);
      else n_pass++;
      n_checks++;
      if (a_busy !== (c <= 8))
        $display("FAIL single_busy c=%0d got=%b exp=%b", c, a_busy, c <= 8);
      else n_pass++;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL single_left got=%0d exp=0", q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    data_in = 8'hB0;
    load_valid = 1'b1;
    q.delete();
    push_msb(8'hB0);
    push_msb(8'h5A);
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      load_valid = (c <= 8);
      data_in = 8'h5A;
      #1;
      n_checks++;
      if (a_valid !== (c <= 16))
        $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, a_valid, c <= 16);
      else n_pass++;
      if (a_valid && q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (a_ser !== e) $display("FAIL b2b_bit c=%0d got=%b exp=%b", c, a_ser, e);
        else n_pass++;
      end
      n_checks++;
      if (a_done !== (c == 9 || c == 17))
        $display("FAIL b2b_done c=%0d got=%b exp=%b", c, a_done, c == 9 || c == 17);
      else n_pass++;
      if (c <= 8) begin
        n_checks++;
        if (a_ready !== (c == 8))
          $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, a_ready, c == 8);
        else n_pass++;
      end
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL b2b_left got=%0d exp=0", q.size());
    else n_pass++;
    data_in = 8'h00;
  endtask

  task automatic test_hold();
    logic h;
    @(posedge clk); #1;
    data_in = 8'hB0;
    load_valid = 1'b1;
    q.delete();
    push_msb(8'hB0);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      load_valid = 1'b0;
      h = (c >= 3 && c <= 5);
      hold = h;
      #1;
      n_checks++;
      if (a_valid !== (!h && c <= 11))
        $display("FAIL hold_valid c=%0d got=%b exp=%b", c, a_valid, !h && c <= 11);
      else n_pass++;
      if (h) begin
        n_checks++;
        if (a_ser !== 1'b1 || a_busy !== 1'b1)
          $display("FAIL hold_frozen c=%0d got=%b%b exp=11", c, a_ser, a_busy);
        else n_pass++;
      end
      if (a_valid && q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (a_ser !== e) $display("FAIL hold_bit c=%0d got=%b exp=%b", c, a_ser, e);
        else n_pass++;
      end
      n_checks++;
      if (a_done !== (c == 12))
        $display("FAIL hold_done c=%0d got=%b exp=%b", c, a_done, c == 12);
      else n_pass++;
    end
    hold = 1'b0;
    n_checks++;
    if (q.size() != 0) $display("FAIL hold_left got=%0d exp=0", q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    data_in = 8'hFF;
    load_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      load_valid = 1'b0;
      #1;
      n_checks++;
      if (a_ser !== 1'b1 || a_valid !== 1'b1)
        $display("FAIL rmid_pre c=%0d got=%b%b exp=11", c, a_ser, a_valid);
      else n_pass++;
    end
    @(posedge clk); #1;
    rstb = 1'b0;
    #1;
    n_checks++;
    if (a_ser !== 1'b0 || a_busy !== 1'b0 || a_valid !== 1'b0)
      $display("FAIL rmid_abort got=%b%b%b exp=000", a_ser, a_busy, a_valid);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_done !== 1'b0) $display("FAIL rmid_nodone c=%0d got=%b exp=0", c, a_done);
      else n_pass++;
    end
    rstb = 1'b1;
    data_in = 8'h0F;
    load_valid = 1'b1;
    q.delete();
    push_msb(8'h0F);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      load_valid = 1'b0;
      #1;
      n_checks++;
      if (a_valid !== (c <= 8))
        $display("FAIL rmid_valid c=%0d got=%b exp=%b", c, a_valid, c <= 8);
      else n_pass++;
      if (a_valid && q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (a_ser !== e) $display("FAIL rmid_bit c=%0d got=%b exp=%b", c, a_ser, e);
        else n_pass++;
      end
      n_checks++;
      if (a_done !== (c == 9))
        $display("FAIL rmid_done c=%0d got=%b exp=%b", c, a_done, c == 9);
      else n_pass++;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL rmid_left got=%0d exp=0", q.size());
    else n_pass++;
  endtask

  task automatic test_lsb_first();
    @(posedge clk); #1;
    data_in = 8'h0D;
    load_valid = 1'b1;
    q.delete();
    push_lsb(8'h0D);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      load_valid = 1'b0;
      #1;
      n_checks++;
      if (b_valid !== (c <= 8))
        $display("FAIL lsb_valid c=%0d got=%b exp=%b", c, b_valid, c <= 8);
      else n_pass++;
      if (b_valid && q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (b_ser !== e) $display("FAIL lsb_bit c=%0d got=%b exp=%b", c, b_ser, e);
        else n_pass++;
      end else begin
        n_checks++;
        if (b_ser !== 1'b1) $display("FAIL lsb_idle c=%0d got=%b exp=1", c, b_ser);
        else n_pass++;
      end
      n_checks++;
      if (b_done !== (c == 9))
        $display("FAIL lsb_done c=%0d got=%b exp=%b", c, b_done, c == 9);
      else n_pass++;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL lsb_left got=%0d exp=0", q.size());
    else n_pass++;
  endtask

  task automatic test_hold_idle();
    @(posedge clk); #1;
    hold = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0)
      $display("FAIL hidle_quiet got=%b%b exp=10", a_ready, a_busy);
    else n_pass++;
    @(posedge clk); #1;
    data_in = 8'hA5;
    load_valid = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) $display("FAIL hidle_ready got=%b exp=1", a_ready);
    else n_pass++;
    q.delete();
    push_msb(8'hA5);
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      load_valid = 1'b0;
      hold = (c <= 3);
      #1;
      n_checks++;
      if (a_busy !== (c <= 11))
        $display("FAIL hidle_busy c=%0d got=%b exp=%b", c, a_busy, c <= 11);
      else n_pass++;
      if (c <= 3) begin
        n_checks++;
        if (a_ser !== 1'b1 || a_valid !== 1'b0)
          $display("FAIL hidle_frozen c=%0d got=%b%b exp=10", c, a_ser, a_valid);
        else n_pass++;
      end
      if (a_valid && q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (a_ser !== e) $display("FAIL hidle_bit c=%0d got=%b exp=%b", c, a_ser, e);
        else n_pass++;
      end
      n_checks++;
      if (a_done !== (c == 12))
        $display("FAIL hidle_done c=%0d got=%b exp=%b", c, a_done, c == 12);
      else n_pass++;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL hidle_left got=%0d exp=0", q.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_lsb_first();
    test_hold_idle();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
